// File: rtl/boxhead_gfx_pkg.sv
// Shared graphics constants and types for the sprite blitter and its pixel FIFO.
package boxhead_gfx_pkg;

   localparam int          SCREEN_W    = 640;
   localparam int          SCREEN_H    = 480;
   localparam logic [15:0] TRANSPARENT = 16'hF81F;
   localparam logic [9:0]  PARK_X      = 10'd1023;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } blit_state_e;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] data;
   } pixel_t;

   // Off-screen address the controller can write harmlessly on idle slots.
   localparam pixel_t PARK_PIXEL = '{x: PARK_X, y: 10'd0, data: 16'd0};

endpackage

// File: rtl/blit_skid_fifo.sv
// Two-entry pixel FIFO between the ROM return path and the output register.
// Push and pop may happen in the same cycle; flush empties it synchronously.
module blit_skid_fifo
   import boxhead_gfx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_flush,
   input  logic       i_push,
   input  pixel_t     i_data,
   input  logic       i_pop,
   output pixel_t     o_head,
   output logic [1:0] o_count
);

   pixel_t     r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_do_push;
   logic       w_do_pop;

   assign w_do_push = i_push && (r_count != 2'd2);
   assign w_do_pop  = i_pop && (r_count != 2'd0);

   // Pointer and occupancy tracking.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/sprite_blitter.sv
// Walks one sprite from ROM and feeds opaque, on-screen pixels to the frame-buffer
// controller's write slots, parking the write address on every other slot.
//
// state | meaning
// IDLE  | waiting for a draw command, cmd_ready high
// FETCH | issuing ROM reads row by row, throttled by FIFO room
// DRAIN | all reads issued; waiting for the last pixel to be consumed
module sprite_blitter
   import boxhead_gfx_pkg::*;
#(
   parameter int SPRITE_W_LOG2 = 5,
   parameter int SPRITE_H_LOG2 = 5,
   parameter int SPRITE_ID_W   = 4
) (
   input  logic                                          sram_clk,
   input  logic                                          reset_n,
   input  logic                                          frame_start,
   input  logic                                          cmd_valid,
   output logic                                          cmd_ready,
   input  logic [9:0]                                    cmd_x,
   input  logic [9:0]                                    cmd_y,
   input  logic [SPRITE_ID_W-1:0]                        cmd_sprite_id,
   output logic [SPRITE_ID_W+SPRITE_H_LOG2+SPRITE_W_LOG2-1:0] rom_addr,
   input  logic [15:0]                                   rom_data,
   input  logic                                          write_slot,
   output logic [9:0]                                    program_x,
   output logic [9:0]                                    program_y,
   output logic [15:0]                                   program_data,
   output logic                                          busy,
   output logic                                          done
);

   localparam int POS_W = SPRITE_H_LOG2 + SPRITE_W_LOG2;

   blit_state_e              r_state;
   blit_state_e              w_state_nxt;
   logic [9:0]               r_x;
   logic [9:0]               r_y;
   logic [SPRITE_ID_W-1:0]   r_id;
   logic [POS_W-1:0]         r_pos;
   logic                     r_inflight;
   logic [10:0]              r_fl_x;
   logic [10:0]              r_fl_y;
   pixel_t                   r_out;
   logic                     r_out_valid;

   logic                     w_accept;
   logic                     w_issue;
   logic [SPRITE_W_LOG2-1:0] w_col;
   logic [SPRITE_H_LOG2-1:0] w_row;
   logic [10:0]              w_sum_x;
   logic [10:0]              w_sum_y;
   logic                     w_push;
   pixel_t                   w_push_pix;
   logic                     w_load;
   logic                     w_pop;
   logic                     w_drained;
   pixel_t                   w_head;
   logic [1:0]               w_count;

   // r_pos is {row, col}, so a plain increment gives scan order with row carry.
   assign w_col   = r_pos[SPRITE_W_LOG2-1:0];
   assign w_row   = r_pos[POS_W-1:SPRITE_W_LOG2];
   assign w_sum_x = {1'b0, r_x} + 11'(w_col);
   assign w_sum_y = {1'b0, r_y} + 11'(w_row);

   // Only issue when the pixel could still fit in the FIFO if it turns out opaque.
   assign w_issue = (r_state == FETCH) && (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2);

   // 11-bit sums keep large X/Y from wrapping back onto the screen.
   assign w_push = r_inflight && !frame_start && (rom_data != TRANSPARENT) &&
                   (r_fl_x < 11'(SCREEN_W)) && (r_fl_y < 11'(SCREEN_H));
   assign w_push_pix = '{x: r_fl_x[9:0], y: r_fl_y[9:0], data: rom_data};

   // The register reloads when the controller has just sampled it or when it holds park.
   assign w_load    = write_slot || !r_out_valid;
   assign w_pop     = !frame_start && w_load && (w_count != 2'd0);
   assign w_drained = !r_inflight && (w_count == 2'd0) && !r_out_valid;

   blit_skid_fifo u_fifo (
      .i_clk   (sram_clk),
      .i_rst_n (reset_n),
      .i_flush (frame_start),
      .i_push  (w_push),
      .i_data  (w_push_pix),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // State register.
   always_ff @(posedge sram_clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs; frame_start overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      done        = 1'b0;
      w_accept    = 1'b0;
      if (frame_start) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = FETCH;
               end
            end
            FETCH: begin
               if (w_issue && (&r_pos)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
               if (w_drained) begin
                  done        = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Command latch, scan position and the single outstanding ROM read.
   always_ff @(posedge sram_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_id       <= '0;
         r_pos      <= '0;
         r_inflight <= 1'b0;
         r_fl_x     <= '0;
         r_fl_y     <= '0;
      end else begin
         if (w_accept) begin
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_id  <= cmd_sprite_id;
            r_pos <= '0;
         end else if (w_issue && !frame_start) begin
            r_pos <= r_pos + 1'b1;
         end
         r_inflight <= w_issue && !frame_start;
         if (w_issue) begin
            r_fl_x <= w_sum_x;
            r_fl_y <= w_sum_y;
         end
      end
   end

   // Output register presented to the controller's write port.
   always_ff @(posedge sram_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out       <= PARK_PIXEL;
         r_out_valid <= 1'b0;
      end else if (frame_start) begin
         r_out       <= PARK_PIXEL;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         if (w_count != 2'd0) begin
            r_out       <= w_head;
            r_out_valid <= 1'b1;
         end else begin
            r_out       <= PARK_PIXEL;
            r_out_valid <= 1'b0;
         end
      end
   end

   assign rom_addr     = {r_id, r_pos};
   assign program_x    = r_out.x;
   assign program_y    = r_out.y;
   assign program_data = r_out.data;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench: each command pushes its expected pixel stream, a negedge monitor
// pops and compares every non-park pixel seen on a write slot.
module tb_sprite_blitter;

   logic        sram_clk      = 1'b0;
   logic        reset_n       = 1'b1;
   logic        frame_start   = 1'b0;
   logic        cmd_valid     = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_x         = '0;
   logic [9:0]  cmd_y         = '0;
   logic [3:0]  cmd_sprite_id = '0;
   logic [13:0] rom_addr;
   logic [15:0] rom_data      = '0;
   logic        write_slot    = 1'b0;
   logic [9:0]  program_x;
   logic [9:0]  program_y;
   logic [15:0] program_data;
   logic        busy;
   logic        done;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] d;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_writes = 0;
   int   done_cnt = 0;
   int   rom_mode = 0;
   int   ph       = 0;
   logic ws_en    = 1'b1;

   sprite_blitter dut (
      .sram_clk      (sram_clk),
      .reset_n       (reset_n),
      .frame_start   (frame_start),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .cmd_sprite_id (cmd_sprite_id),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .write_slot    (write_slot),
      .program_x     (program_x),
      .program_y     (program_y),
      .program_data  (program_data),
      .busy          (busy),
      .done          (done)
   );

   initial forever #5 sram_clk = ~sram_clk;

   // ROM contents: 0 opaque, 1 checkerboard with transparent, 2 all transparent.
   function automatic logic [15:0] rom_val(int mode, logic [13:0] a);
      if (mode == 2) return 16'hF81F;
      if (mode == 1 && (a[5] ^ a[0])) return 16'hF81F;
      return {2'b00, a};
   endfunction

   always @(posedge sram_clk) rom_data <= rom_val(rom_mode, rom_addr);

   // Controller write slots: two of every four cycles.
   initial forever begin
      @(posedge sram_clk);
      #1;
      ph = ph + 1;
      write_slot = ws_en && ((ph % 4) >= 2);
   end

   // Monitor: every non-park pixel on a write slot must be the next expected one.
   always @(negedge sram_clk) begin : mon
      exp_t e;
      if (done) done_cnt++;
      if (write_slot && program_x != 10'd1023) begin
         n_writes++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL pixel_unexpected got (%0d,%0d,%h) want none",
                     program_x, program_y, program_data);
         end else begin
            e = sb.pop_front();
            if (program_x != 10'(e.x) || program_y != 10'(e.y) || program_data != e.d) begin
               failures++;
               $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                        program_x, program_y, program_data, e.x, e.y, e.d);
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic check_park_reset(string tag);
      chk({tag, "_program_x"}, 32'(program_x), 32'd1023);
      chk({tag, "_program_y"}, 32'(program_y), 32'd0);
      chk({tag, "_program_data"}, 32'(program_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
   endtask

   task automatic push_exp(int x, int y, int id, int mode);
      int          xs;
      int          ys;
      logic [15:0] d;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            xs = x + c;
            ys = y + r;
            d  = rom_val(mode, 14'(id * 1024 + r * 32 + c));
            if (d != 16'hF81F && xs < 640 && ys < 480) sb.push_back('{xs, ys, d});
         end
      end
   endtask

   task automatic send_cmd(int x, int y, int id);
      logic ok;
      ok = 1'b0;
      @(posedge sram_clk);
      #1;
      cmd_x         = 10'(x);
      cmd_y         = 10'(y);
      cmd_sprite_id = 4'(id);
      cmd_valid     = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge sram_clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge sram_clk);
      #1;
      cmd_valid = 1'b0;
      chk("cmd_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(int d0, int w0, int stall_at);
      logic        stalled;
      logic [13:0] a;
      stalled = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(posedge sram_clk);
         if (done_cnt > d0) break;
         if (stall_at > 0 && !stalled && (n_writes - w0) >= stall_at) begin
            stalled = 1'b1;
            ws_en   = 1'b0;
            repeat (6) @(posedge sram_clk);
            #1;
            a = rom_addr;
            repeat (44) @(posedge sram_clk);
            #1;
            chk("stall_rom_addr", 32'(rom_addr), 32'(a));
            ws_en = 1'b1;
         end
      end
      chk("done_seen", 32'(done_cnt > d0), 32'd1);
      repeat (4) @(posedge sram_clk);
   endtask

   task automatic run_blit(string name, int x, int y, int id, int mode, int exp_w, int stall_at);
      int w0;
      int d0;
      rom_mode = mode;
      w0 = n_writes;
      d0 = done_cnt;
      push_exp(x, y, id, mode);
      send_cmd(x, y, id);
      wait_done(d0, w0, stall_at);
      chk({name, "_writes"}, 32'(n_writes - w0), 32'(exp_w));
      chk({name, "_left"}, 32'(sb.size()), 32'd0);
      chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({name, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin : main
      int w0;
      int d0;
      int ab_ok;

      #3 reset_n = 1'b0;
      #1 check_park_reset("por");
      repeat (3) @(posedge sram_clk);
      @(negedge sram_clk);
      reset_n = 1'b1;

      run_blit("opaque", 100, 50, 3, 0, 1024, 0);
      run_blit("checker", 200, 100, 5, 1, 512, 0);
      run_blit("corner", 625, 470, 7, 0, 150, 0);
      run_blit("xwrap", 1020, 0, 9, 0, 0, 0);
      run_blit("clear", 0, 0, 6, 2, 0, 0);
      run_blit("stall", 10, 10, 2, 0, 1024, 300);

      // frame_start abort with a competing command in the same cycle
      rom_mode = 0;
      w0 = n_writes;
      d0 = done_cnt;
      push_exp(300, 200, 4, 0);
      send_cmd(300, 200, 4);
      ab_ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge sram_clk);
         if ((n_writes - w0) >= 200) begin
            ab_ok = 1;
            break;
         end
      end
      chk("abort_reached_200", 32'(ab_ok), 32'd1);
      #1;
      frame_start   = 1'b1;
      cmd_valid     = 1'b1;
      cmd_x         = 10'd40;
      cmd_y         = 10'd30;
      cmd_sprite_id = 4'd1;
      @(negedge sram_clk);
      chk("abort_cmd_ready_low", 32'(cmd_ready), 32'd0);
      @(posedge sram_clk);
      #1;
      frame_start = 1'b0;
      sb.delete();
      chk("abort_park_x", 32'(program_x), 32'd1023);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      push_exp(40, 30, 1, 0);
      w0 = n_writes;
      @(negedge sram_clk);
      chk("abort_cmd_ready_next", 32'(cmd_ready), 32'd1);
      @(posedge sram_clk);
      #1;
      cmd_valid = 1'b0;
      chk("abort_new_busy", 32'(busy), 32'd1);
      wait_done(d0, w0, 0);
      chk("abort_new_writes", 32'(n_writes - w0), 32'd1024);
      chk("abort_new_done", 32'(done_cnt - d0), 32'd1);
      chk("abort_new_left", 32'(sb.size()), 32'd0);

      // asynchronous reset in the middle of FETCH
      push_exp(0, 0, 2, 0);
      send_cmd(0, 0, 2);
      repeat (20) @(posedge sram_clk);
      #1;
      chk("rst_mid_busy_before", 32'(busy), 32'd1);
      @(posedge sram_clk);
      #2 reset_n = 1'b0;
      #1 check_park_reset("rst_mid");
      sb.delete();
      w0 = n_writes;
      d0 = done_cnt;
      repeat (3) @(posedge sram_clk);
      @(negedge sram_clk);
      reset_n = 1'b1;
      repeat (60) @(posedge sram_clk);
      chk("rst_mid_no_writes", 32'(n_writes - w0), 32'd0);
      chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      chk("rst_mid_busy_after", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
